// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    localparam logic P_VID = 1'b0;
    localparam logic P_CPU = 1'b1;

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational winner select for the RAM arbiter.
// RAM_ARB_RR_EN selects round-robin on ties; otherwise the video port wins ties.
module arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef RAM_ARB_RR_EN
    input  logic rr_last,
`endif
    output logic grant
);

    always_comb begin
        grant = P_VID;
        if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
            // The port that was not granted last time gets the slot.
            grant = ~rr_last;
`else
            grant = P_VID;
`endif
        end else if (req1) begin
            grant = P_CPU;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the video (port 0) and CPU (port 1) requesters.
// Optional RAM_ARB_RR_EN switches tie-breaking from fixed priority to round-robin.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] a0,
    input  logic [7:0]    d0,
    output logic [7:0]    q0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] a1,
    input  logic [7:0]    d1,
    output logic [7:0]    q1,
    output logic          ack1,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    output logic          ram_w,
    input  logic [7:0]    ram_q,
    output logic          busy
);

    state_t state, state_nxt;
    logic   grant;
    logic   sel;
    logic   start;

`ifdef RAM_ARB_RR_EN
    logic rr_last;

    arb_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last),
        .grant   (grant)
    );
`else
    arb_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .grant (grant)
    );
`endif

    assign start = (state == ST_IDLE) && (req0 || req1);
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req0 || req1) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_DATA;
            ST_DATA:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Pin registers: loaded only on a grant; the write strobe lasts exactly one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_a   <= '0;
            ram_d   <= '0;
            ram_w   <= 1'b0;
            sel     <= P_VID;
`ifdef RAM_ARB_RR_EN
            rr_last <= P_CPU;
`endif
        end else begin
            ram_w <= 1'b0;
            if (start) begin
                ram_a   <= (grant == P_CPU) ? a1  : a0;
                ram_d   <= (grant == P_CPU) ? d1  : d0;
                ram_w   <= (grant == P_CPU) ? we1 : we0;
                sel     <= grant;
`ifdef RAM_ARB_RR_EN
                rr_last <= grant;
`endif
            end
        end
    end

    // Return path: RAM output is captured in DATA, so writes echo the written byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q0   <= 8'h00;
            q1   <= 8'h00;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (state == ST_DATA) begin
                if (sel == P_CPU) begin
                    q1   <= ram_q;
                    ack1 <= 1'b1;
                end else begin
                    q0   <= ram_q;
                    ack0 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, corner sequences and randomized traffic.
// Tie-break expectations follow RAM_ARB_RR_EN when it is defined for the build.
module tb_ram_arbiter;

    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [7:0]    d0 = '0, d1 = '0;
    logic [7:0]    q0, q1, ram_d, ram_q;
    logic          ack0, ack1, ram_w, busy;
    logic [AW-1:0] ram_a;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural RAM: 1-cycle read latency, write-through output.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (ram_w) mem[ram_a] <= ram_d;
        ram_q <= ram_w ? ram_d : mem[ram_a];
    end

    always #5 clock = ~clock;

    ram_arbiter #(.AW(AW)) dut (
        .clock (clock), .reset (reset),
        .req0 (req0), .we0 (we0), .a0 (a0), .d0 (d0), .q0 (q0), .ack0 (ack0),
        .req1 (req1), .we1 (we1), .a1 (a1), .d1 (d1), .q1 (q1), .ack1 (ack1),
        .ram_a (ram_a), .ram_d (ram_d), .ram_w (ram_w), .ram_q (ram_q), .busy (busy)
    );

    // Reference model: byte-addressed memory plus last-granted port.
    logic [7:0] ref_mem [int];
    bit         rr_m = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    function automatic bit model_pick(input bit r0, input bit r1);
        bit w;
        if (r0 && r1) begin
`ifdef RAM_ARB_RR_EN
            w = !rr_m;
`else
            w = 1'b0;
`endif
        end else begin
            w = r1;
        end
        return w;
    endfunction

    function automatic logic [7:0] ref_access(input bit w, input int a, input logic [7:0] d);
        if (w) ref_mem[a] = d;
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    // Predicts ack edges (counted from the first edge that sees req) and returned bytes.
    task automatic model_txn(input bit r0, r1, w0, w1, input logic [15:0] ia0, ia1,
                             input logic [7:0] id0, id1,
                             output int e0, e1, output logic [7:0] qe0, qe1);
        bit order [2];
        int n;
        e0 = 0; e1 = 0; qe0 = 8'h00; qe1 = 8'h00;
        order[0] = model_pick(r0, r1);
        order[1] = !order[0];
        n = (r0 && r1) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            if (order[k] == 1'b0) begin
                qe0 = ref_access(w0, int'(ia0), id0);
                e0  = 3 * (k + 1);
            end else begin
                qe1 = ref_access(w1, int'(ia1), id1);
                e1  = 3 * (k + 1);
            end
            rr_m = order[k];
        end
    endtask

    // Drives one request set (one or both ports) from a negedge, dropping each req in its ack cycle.
    task automatic run_pair(input bit r0, r1, w0, w1, input logic [15:0] ia0, ia1,
                            input logic [7:0] id0, id1,
                            output int e0, e1, output logic [7:0] g0, g1,
                            output int nw, output logic [15:0] wa, output int nbusy,
                            output int late_ack);
        req0 = r0; we0 = w0; a0 = ia0; d0 = id0;
        req1 = r1; we1 = w1; a1 = ia1; d1 = id1;
        e0 = 0; e1 = 0; g0 = 8'h00; g1 = 8'h00; nw = 0; wa = '0; nbusy = 0; late_ack = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (ram_w) begin nw++; wa = ram_a; end
            if (busy) nbusy++;
            if (ack0) begin
                if (!r0 || e0 != 0) late_ack++;
                e0 = c; g0 = q0; req0 = 1'b0;
            end
            if (ack1) begin
                if (!r1 || e1 != 0) late_ack++;
                e1 = c; g1 = q1; req1 = 1'b0;
            end
            if ((!r0 || e0 != 0) && (!r1 || e1 != 0)) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        if (ack0 || ack1) late_ack++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        rr_m = 1'b1;
    endtask

    typedef struct {
        string      name;
        bit         r0, r1, w0, w1;
        logic [15:0] a0, a1;
        logic [7:0] d0, d1;
        int         ee0, ee1;
        logic [7:0] eq0, eq1;
    } vec_t;

    vec_t vt [6];

    initial begin
        int         e0, e1, m0, m1, nw, nbusy, late, bad;
        logic [7:0] g0, g1, x0, x1;
        logic [15:0] wa;
        bit         r0, r1, w0, w1;
        logic [15:0] ra0, ra1;
        logic [7:0] rd0, rd1;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;

        vt[0] = '{"p1_wr_1234", 0, 1, 0, 1, 16'h0000, 16'h1234, 8'h00, 8'hA5, 0, 3, 8'h00, 8'hA5};
        vt[1] = '{"p1_rd_1234", 0, 1, 0, 0, 16'h0000, 16'h1234, 8'h00, 8'h00, 0, 3, 8'h00, 8'hA5};
        vt[2] = '{"p0_wr_ffff", 1, 0, 1, 0, 16'hFFFF, 16'h0000, 8'h3C, 8'h00, 3, 0, 8'h3C, 8'h00};
        vt[3] = '{"p0_rd_ffff", 1, 0, 0, 0, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 3, 0, 8'h3C, 8'h00};
`ifdef RAM_ARB_RR_EN
        vt[4] = '{"dual_a", 1, 1, 0, 1, 16'h1234, 16'h0010, 8'h00, 8'h5A, 6, 3, 8'hA5, 8'h5A};
        vt[5] = '{"dual_b", 1, 1, 1, 0, 16'h0010, 16'h0010, 8'h11, 8'h00, 6, 3, 8'h11, 8'h5A};
`else
        vt[4] = '{"dual_a", 1, 1, 0, 1, 16'h1234, 16'h0010, 8'h00, 8'h5A, 3, 6, 8'hA5, 8'h5A};
        vt[5] = '{"dual_b", 1, 1, 1, 0, 16'h0010, 16'h0010, 8'h11, 8'h00, 3, 6, 8'h11, 8'h11};
`endif

        // Reset state.
        #12;
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_d", ram_d, 0);
        chk("rst_ram_w", ram_w, 0);
        chk("rst_q", {q1, q0}, 0);
        chk("rst_ack", {ack1, ack0}, 0);
        chk("rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            model_txn(vt[i].r0, vt[i].r1, vt[i].w0, vt[i].w1, vt[i].a0, vt[i].a1,
                      vt[i].d0, vt[i].d1, m0, m1, x0, x1);
            run_pair(vt[i].r0, vt[i].r1, vt[i].w0, vt[i].w1, vt[i].a0, vt[i].a1,
                     vt[i].d0, vt[i].d1, e0, e1, g0, g1, nw, wa, nbusy, late);
            chk({vt[i].name, "_ack0_edge"}, e0, vt[i].ee0);
            chk({vt[i].name, "_ack1_edge"}, e1, vt[i].ee1);
            if (vt[i].r0) chk({vt[i].name, "_q0"}, g0, vt[i].eq0);
            if (vt[i].r1) chk({vt[i].name, "_q1"}, g1, vt[i].eq1);
            chk({vt[i].name, "_writes"}, nw, (vt[i].r0 & vt[i].w0) + (vt[i].r1 & vt[i].w1));
            chk({vt[i].name, "_busy_cycles"}, nbusy, 2 * (vt[i].r0 + vt[i].r1));
            chk({vt[i].name, "_stray_ack"}, late, 0);
            if (vt[i].r1 && vt[i].w1 && !vt[i].r0) chk({vt[i].name, "_wr_addr"}, wa, vt[i].a1);
        end

        // Both ports hold req through ack: a new grant starts every third edge.
        do_reset();
        req0 = 1'b1; we0 = 1'b0; a0 = 16'h1234;
        req1 = 1'b1; we1 = 1'b0; a1 = 16'hFFFF;
        begin
            int got [4];
            int nack;
            bit w;
            nack = 0;
            for (int k = 0; k < 4; k++) got[k] = -1;
            for (int c = 1; c <= 12; c++) begin
                @(posedge clock);
                @(negedge clock);
                if (ack0 || ack1) begin
                    if (c % 3 == 0 && nack < 4) got[nack] = ack1 ? 1 : 0;
                    nack++;
                end
            end
            req0 = 1'b0; req1 = 1'b0;
            chk("hold_ack_count", nack, 4);
            for (int k = 0; k < 4; k++) begin
                w = model_pick(1'b1, 1'b1);
                rr_m = w;
                chk($sformatf("hold_grant_%0d", k), got[k], int'(w));
            end
        end
        @(negedge clock);
        @(negedge clock);

        // Reset between E0 and E1 of a write: nothing committed, no ack.
        @(negedge clock);
        req1 = 1'b1; we1 = 1'b1; a1 = 16'h0010; d1 = 8'hEE;
        @(posedge clock);
        #2;
        chk("abort_w_in_flight", ram_w, 1);
        reset = 1'b1;
        #1;
        chk("abort_w_cleared", ram_w, 0);
        chk("abort_busy", busy, 0);
        req1 = 1'b0;
        #1;
        reset = 1'b0;
        rr_m = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (ack0 || ack1 || busy) bad++;
        end
        chk("abort_quiet", bad, 0);
        model_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0010, 8'h0, 8'h0, m0, m1, x0, x1);
        run_pair(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0010, 8'h0, 8'h0, e0, e1, g0, g1, nw, wa, nbusy, late);
        chk("abort_mem_unchanged", g1, x1);
        chk("abort_ack1_edge", e1, m1);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            r0 = $urandom_range(0, 1);
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            w0 = $urandom_range(0, 1);
            w1 = $urandom_range(0, 1);
            ra0 = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 7));
            rd0 = 8'($urandom);
            rd1 = 8'($urandom);
            model_txn(r0, r1, w0, w1, ra0, ra1, rd0, rd1, m0, m1, x0, x1);
            run_pair(r0, r1, w0, w1, ra0, ra1, rd0, rd1, e0, e1, g0, g1, nw, wa, nbusy, late);
            chk($sformatf("rnd%0d_ack0_edge", it), e0, m0);
            chk($sformatf("rnd%0d_ack1_edge", it), e1, m1);
            if (r0) chk($sformatf("rnd%0d_q0", it), g0, x0);
            if (r1) chk($sformatf("rnd%0d_q1", it), g1, x1);
            chk($sformatf("rnd%0d_stray_ack", it), late, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
